// File: rtl/picosoc_bus_bridge_if.sv
// Bus bundle between the picorv32 native port, the RAM wrapper and the IO port.
// slave = the bridge's view; master = the CPU/RAM/peripheral environment.
interface picosoc_bus_bridge_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic [3:0]  ram_wen;
  logic [21:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ready;

  logic        iomem_valid;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic        iomem_ready;
  logic [31:0] iomem_rdata;

  logic        bus_err;

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata,
    output ram_wen, ram_addr, ram_wdata,
    input  ram_rdata, ram_ready,
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata,
    output bus_err
  );

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata,
    input  ram_wen, ram_addr, ram_wdata,
    output ram_rdata, ram_ready,
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata,
    input  bus_err
  );
endinterface

// File: rtl/picosoc_bus_bridge.sv
// picorv32 native bus -> on-chip RAM / iomem bridge with registered outputs.
// Define BUS_TIMEOUT_EN to bound IO waits to TIMEOUT_CYCLES and flag expiry on bus_err.
module picosoc_bus_bridge #(
  parameter int unsigned RAM_WORDS      = 1024,
  parameter logic [7:0]  IO_BASE_HI     = 8'h02,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       resetn,
  picosoc_bus_bridge_if.slave        bus
);
  localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

  if (RAM_BYTES > {IO_BASE_HI, 24'h0} || TIMEOUT_CYCLES == 0) begin : g_cfg_err
    $error("picosoc_bus_bridge: RAM region overlaps IO_BASE_HI or TIMEOUT_CYCLES is 0");
  end

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, RD_CAP, WR_GUARD, WR_WAIT, IO_WAIT, DONE
  } state_e;

  state_e      state_q, state_d;
  logic        mem_ready_q, mem_ready_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic [3:0]  ram_wen_q, ram_wen_d;
  logic [21:0] ram_addr_q, ram_addr_d;
  logic [31:0] ram_wdata_q, ram_wdata_d;
  logic        iomem_valid_q, iomem_valid_d;
  logic [3:0]  iomem_wstrb_q, iomem_wstrb_d;
  logic [31:0] iomem_addr_q, iomem_addr_d;
  logic [31:0] iomem_wdata_q, iomem_wdata_d;
  logic        bus_err_q, bus_err_d;
  logic        ram_hit, io_hit, wen_partial;

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] io_cnt_q, io_cnt_d;
`endif

  assign ram_hit     = bus.mem_addr < RAM_BYTES;
  assign io_hit      = bus.mem_addr[31:24] == IO_BASE_HI;
  assign wen_partial = (ram_wen_q != 4'h0) && (ram_wen_q != 4'hF);

  always_comb begin
    state_d       = state_q;
    mem_ready_d   = 1'b0;
    mem_rdata_d   = mem_rdata_q;
    ram_wen_d     = ram_wen_q;
    ram_addr_d    = ram_addr_q;
    ram_wdata_d   = ram_wdata_q;
    iomem_valid_d = iomem_valid_q;
    iomem_wstrb_d = iomem_wstrb_q;
    iomem_addr_d  = iomem_addr_q;
    iomem_wdata_d = iomem_wdata_q;
    bus_err_d     = bus_err_q;
`ifdef BUS_TIMEOUT_EN
    io_cnt_d      = io_cnt_q;
`endif
    case (state_q)
      // mem_ready_q high means the CPU is still holding the request it just
      // completed; skipping that cycle prevents a second issue.
      IDLE: if (bus.mem_valid && !mem_ready_q) begin
        if (ram_hit) begin
          ram_addr_d  = bus.mem_addr[23:2];
          ram_wdata_d = bus.mem_wdata;
          if (bus.mem_wstrb == 4'h0) begin
            state_d = RD_WAIT;
          end else begin
            ram_wen_d = bus.mem_wstrb;
            state_d   = WR_GUARD;
          end
        end else if (io_hit) begin
          iomem_valid_d = 1'b1;
          iomem_addr_d  = bus.mem_addr;
          iomem_wdata_d = bus.mem_wdata;
          iomem_wstrb_d = bus.mem_wstrb;
`ifdef BUS_TIMEOUT_EN
          io_cnt_d      = '0;
`endif
          state_d       = IO_WAIT;
        end else begin
          bus_err_d   = 1'b1;
          mem_rdata_d = 32'h0;
          state_d     = WR_GUARD;
        end
      end
      RD_WAIT: state_d = RD_CAP;
      RD_CAP: begin
        mem_rdata_d = bus.ram_rdata;
        state_d     = DONE;
      end
      // One-cycle settle shared by all writes and unmapped accesses; only a
      // partial write goes on to wait for the RAM, since ram_ready is stale here.
      WR_GUARD: begin
        if (wen_partial) begin
          state_d = WR_WAIT;
        end else begin
          ram_wen_d = 4'h0;
          state_d   = DONE;
        end
      end
      WR_WAIT: if (bus.ram_ready) begin
        ram_wen_d = 4'h0;
        state_d   = DONE;
      end
      IO_WAIT: begin
        if (bus.iomem_ready) begin
          mem_rdata_d   = bus.iomem_rdata;
          iomem_valid_d = 1'b0;
          state_d       = DONE;
        end
`ifdef BUS_TIMEOUT_EN
        else if (io_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          mem_rdata_d   = 32'hFFFF_FFFF;
          iomem_valid_d = 1'b0;
          bus_err_d     = 1'b1;
          state_d       = DONE;
        end else begin
          io_cnt_d = io_cnt_q + 1'b1;
        end
`endif
      end
      DONE: begin
        mem_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      mem_ready_q   <= 1'b0;
      mem_rdata_q   <= 32'h0;
      ram_wen_q     <= 4'h0;
      ram_addr_q    <= 22'h0;
      ram_wdata_q   <= 32'h0;
      iomem_valid_q <= 1'b0;
      iomem_wstrb_q <= 4'h0;
      iomem_addr_q  <= 32'h0;
      iomem_wdata_q <= 32'h0;
      bus_err_q     <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      io_cnt_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      mem_ready_q   <= mem_ready_d;
      mem_rdata_q   <= mem_rdata_d;
      ram_wen_q     <= ram_wen_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      iomem_valid_q <= iomem_valid_d;
      iomem_wstrb_q <= iomem_wstrb_d;
      iomem_addr_q  <= iomem_addr_d;
      iomem_wdata_q <= iomem_wdata_d;
      bus_err_q     <= bus_err_d;
`ifdef BUS_TIMEOUT_EN
      io_cnt_q      <= io_cnt_d;
`endif
    end
  end

  assign bus.mem_ready   = mem_ready_q;
  assign bus.mem_rdata   = mem_rdata_q;
  assign bus.ram_wen     = ram_wen_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_wdata   = ram_wdata_q;
  assign bus.iomem_valid = iomem_valid_q;
  assign bus.iomem_wstrb = iomem_wstrb_q;
  assign bus.iomem_addr  = iomem_addr_q;
  assign bus.iomem_wdata = iomem_wdata_q;
  assign bus.bus_err     = bus_err_q;
endmodule
